// File: rtl/lsu_stage.sv
// ---------------------------------------------------------------------------
// lsu_stage
//
// Load/store stage that sits directly behind the ALU. The ALU result is the
// effective address and the rt value is the store data. Each accepted
// aligned op runs one req/ack transaction against a variable-latency data
// memory. Load data is aligned and extended, then retired as a one-cycle
// write-back pulse. The upstream pipeline is held through `stall` while a
// transaction is in flight.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   op_valid      op presented; upstream keeps it stable while stall=1
//   op_load       load op (wins over op_store when both are set)
//   op_store      store op
//   op_size       00 byte, 01 half, 10/11 word
//   op_unsigned   1 = zero-extend loads, 0 = sign-extend
//   addr          effective address (ALU result)
//   store_data    rt value; byte/half stores use its low lanes
//   stall         hold upstream
//   wb_valid      one-cycle pulse, wb_data carries a retired load
//   wb_data       aligned/extended load data, holds between loads
//   misalign      one-cycle pulse, misaligned access rejected
//   timeout_err   one-cycle pulse, memory never acknowledged
//   mem_req       request, held until ack or timeout
//   mem_we        1 = write
//   mem_addr      word-aligned address
//   mem_be        byte enables
//   mem_wdata     lane-replicated store data
//   mem_ack       one-cycle completion from memory
//   mem_rdata     read word, valid in the mem_ack cycle
// ---------------------------------------------------------------------------
module lsu_stage #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_load,
  input  logic              op_store,
  input  logic [1:0]        op_size,
  input  logic              op_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign,
  output logic              timeout_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  // The counter holds the number of REQ cycles already completed, so the
  // TIMEOUT-th REQ cycle is the one where it reads TIMEOUT-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t state;
  state_t state_next;

  // Decoded view of the presented op
  logic accept;
  logic is_half;
  logic is_word;
  logic misaligned;
  logic start;
  logic timeout_hit;

  // Request side, formatted from the presented op
  logic [3:0]        be_fmt;
  logic [DATA_W-1:0] wdata_fmt;

  // Transaction context captured at accept time
  logic [ADDR_W-3:0] addr_word_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              we_q;
  logic              is_load_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        cnt_q;
  logic              timeout_err_q;
  logic [DATA_W-1:0] wb_data_q;

  // Load data after lane selection and extension
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] load_ext;

  // Size 11 is treated as a word, so bit 1 alone identifies word accesses.
  assign accept     = op_valid & (op_load | op_store);
  assign is_half    = (op_size == 2'b01);
  assign is_word    = op_size[1];
  assign misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
  assign start      = (state == IDLE) & accept & ~misaligned;

  // An ack on the last allowed cycle still completes the transaction.
  assign timeout_hit = (state == REQ) & ~mem_ack & (cnt_q == TIMEOUT_LAST);

  // Byte enables and lane-replicated write data for the presented op.
  // Replicating the data lets the memory pick it up from whichever lanes
  // the enables select without a shifter on the memory side.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = store_data;
    case (op_size)
      2'b00: begin
        be_fmt    = 4'b0001 << addr[1:0];
        wdata_fmt = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_fmt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{store_data[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = store_data;
      end
    endcase
  end

  // Lane select and extension of the returning read word, driven by the
  // context captured at accept time.
  always_comb begin
    ld_byte  = 8'h00;
    ld_half  = 16'h0000;
    load_ext = mem_rdata;
    case (lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h000000, ld_byte}
                                : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = uns_q ? {16'h0000, ld_half}
                                : {{16{ld_half[15]}}, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE always drains back to IDLE; the op still shown
  // on op_valid during DONE is the one retiring, so it is not re-accepted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction context, timeout counter and write-back register. Context
  // is captured only on accept so the memory-side outputs stay stable for
  // the whole request. wb_data changes only when a load completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_word_q   <= '0;
      lane_q        <= 2'b00;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      we_q          <= 1'b0;
      is_load_q     <= 1'b0;
      be_q          <= 4'b0000;
      wdata_q       <= '0;
      cnt_q         <= 8'd0;
      timeout_err_q <= 1'b0;
      wb_data_q     <= '0;
    end else begin
      if (start) begin
        addr_word_q <= addr[ADDR_W-1:2];
        lane_q      <= addr[1:0];
        size_q      <= op_size;
        uns_q       <= op_unsigned;
        we_q        <= op_store & ~op_load;
        is_load_q   <= op_load;
        be_q        <= be_fmt;
        wdata_q     <= wdata_fmt;
      end

      if (start) begin
        cnt_q <= 8'd0;
      end else if (state == REQ) begin
        cnt_q <= cnt_q + 8'd1;
      end

      timeout_err_q <= timeout_hit;

      if ((state == REQ) && mem_ack && is_load_q) begin
        wb_data_q <= load_ext;
      end
    end
  end

  // Output decode. Memory-side fields are only driven while a request is
  // outstanding so the bus reads as zero whenever the stage is idle.
  always_comb begin
    stall     = 1'b0;
    misalign  = 1'b0;
    wb_valid  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        stall    = start;
        misalign = accept & misaligned;
      end
      REQ: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_word_q, 2'b00};
        mem_be    = be_q;
        mem_wdata = wdata_q;
      end
      DONE: begin
        wb_valid = is_load_q;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign wb_data     = wb_data_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_stage
//
// Self-checking bench for lsu_stage: a table of directed ops with
// hand-written expectations, two hand-written multi-cycle sequences
// (reset mid-request, back-to-back loads) and randomized ops checked
// against a byte-lane reference model.
// ---------------------------------------------------------------------------
module tb_lsu_stage;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_load;
  logic        op_store;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        misalign;
  logic        timeout_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // Last write-back value the model expects wb_data to be holding
  logic [31:0] last_wb;

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    int          ack;
    logic [31:0] rdata;
  } op_t;

  typedef struct {
    int          mis;
    int          req;
    int          stall;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          wb;
    logic [31:0] wbdata;
    int          to;
    int          unstable;
    int          wb_cyc;
    logic [31:0] fin_wb;
  } res_t;

  typedef struct {
    string name;
    op_t   op;
    res_t  exp;
  } vec_t;

  lsu_stage #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_load    (op_load),
    .op_store   (op_store),
    .op_size    (op_size),
    .op_unsigned(op_unsigned),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .misalign   (misalign),
    .timeout_err(timeout_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string what, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
    end
  endtask

  // Reference model: works in byte counts and lane offsets rather than in
  // the enable/extension encodings the design uses.
  function automatic res_t model_op(input op_t op);
    res_t        e;
    int          nb;
    int          lane;
    bit          acked;
    logic [31:0] mask;
    logic [31:0] val;
    e = '{default: 0};
    nb   = (op.size == 2'd0) ? 1 : (op.size == 2'd1) ? 2 : 4;
    lane = int'(op.addr % 32'd4);
    if (!(op.ld || op.st)) return e;
    if ((lane % nb) != 0) begin
      e.mis = 1;
      return e;
    end
    acked   = (op.ack >= 1) && (op.ack <= TIMEOUT);
    e.req   = acked ? op.ack : TIMEOUT;
    e.stall = e.req + 1;
    e.to    = acked ? 0 : 1;
    e.we    = !op.ld;
    e.maddr = op.addr - 32'(lane);
    e.be    = 4'(((1 << nb) - 1) << lane);
    if (nb == 1)      e.wdata = 32'(op.sdata[7:0]) * 32'h0101_0101;
    else if (nb == 2) e.wdata = 32'(op.sdata[15:0]) * 32'h0001_0001;
    else              e.wdata = op.sdata;
    if (op.ld && acked) begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nb)) - 64'd1);
      val  = (op.rdata >> (8 * lane)) & mask;
      if (!op.uns && nb < 4 && val[8*nb-1]) val = val | ~mask;
      e.wb     = 1;
      e.wbdata = val;
    end
    return e;
  endfunction

  function automatic vec_t make_vec(
      input string name, input logic ld, input logic st, input logic [1:0] size,
      input logic uns, input logic [31:0] a, input logic [31:0] sd, input int ack,
      input logic [31:0] rd, input int mis, input int req, input logic we,
      input logic [31:0] maddr, input logic [3:0] be, input logic [31:0] wdata,
      input int wb, input logic [31:0] wbdata, input int to);
    vec_t v;
    v.name = name;
    v.op   = '{ld: ld, st: st, size: size, uns: uns, addr: a, sdata: sd,
               ack: ack, rdata: rd};
    v.exp  = '{default: 0};
    v.exp.mis    = mis;
    v.exp.req    = req;
    v.exp.stall  = (req == 0) ? 0 : req + 1;
    v.exp.we     = we;
    v.exp.maddr  = maddr;
    v.exp.be     = be;
    v.exp.wdata  = wdata;
    v.exp.wb     = wb;
    v.exp.wbdata = wbdata;
    v.exp.to     = to;
    return v;
  endfunction

  // Presents one op, plays the memory (ack on the op's chosen REQ cycle,
  // random stray acks while idle) and records what the stage did. The op is
  // withdrawn once the stage lets upstream advance, or when the request
  // times out and the op is retired by the exception path.
  task automatic applyStimulus(input op_t op, output res_t g);
    int cyc;
    int req_n;
    int quiet;
    bit held;
    bit s_stall;
    bit s_req;
    bit s_ack;
    g = '{default: 0};
    cyc   = 0;
    req_n = 0;
    quiet = 0;
    held  = 1'b1;
    op_valid    = 1'b1;
    op_load     = op.ld;
    op_store    = op.st;
    op_size     = op.size;
    op_unsigned = op.uns;
    addr        = op.addr;
    store_data  = op.sdata;
    mem_ack     = 1'b0;
    while (quiet < 3 && cyc < 64) begin
      @(negedge clk);
      s_stall = stall;
      s_req   = mem_req;
      s_ack   = 1'b0;
      if (misalign)    g.mis++;
      if (stall)       g.stall++;
      if (timeout_err) g.to++;
      if (wb_valid) begin
        g.wb++;
        g.wbdata = wb_data;
        g.wb_cyc = cyc;
      end
      if (mem_req) begin
        req_n++;
        if (req_n == 1) begin
          g.we    = mem_we;
          g.maddr = mem_addr;
          g.be    = mem_be;
          g.wdata = mem_wdata;
        end else if (mem_we !== g.we || mem_addr !== g.maddr ||
                     mem_be !== g.be || mem_wdata !== g.wdata) begin
          g.unstable++;
        end
        if (held && req_n == op.ack) begin
          mem_ack   = 1'b1;
          mem_rdata = op.rdata;
          s_ack     = 1'b1;
        end
      end else if (!held) begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (held) begin
        if (!s_stall || (s_req && req_n == TIMEOUT && !s_ack)) begin
          held     = 1'b0;
          op_valid = 1'b0;
        end
      end else begin
        quiet++;
      end
      cyc++;
    end
    g.req    = req_n;
    g.fin_wb = wb_data;
    checkOutput("op_retired", 32'(held), 32'd0);
    op_valid = 1'b0;
  endtask

  task automatic verify_op(input string name, input res_t e, input res_t g);
    logic [31:0] exp_wb;
    checkOutput({name, ".misalign"}, 32'(g.mis), 32'(e.mis));
    checkOutput({name, ".req_cycles"}, 32'(g.req), 32'(e.req));
    checkOutput({name, ".stall_cycles"}, 32'(g.stall), 32'(e.stall));
    checkOutput({name, ".wb_pulses"}, 32'(g.wb), 32'(e.wb));
    checkOutput({name, ".timeout_err"}, 32'(g.to), 32'(e.to));
    if (e.req > 0) begin
      checkOutput({name, ".mem_addr"}, g.maddr, e.maddr);
      checkOutput({name, ".mem_be"}, 32'(g.be), 32'(e.be));
      checkOutput({name, ".mem_we"}, 32'(g.we), 32'(e.we));
      if (e.we) checkOutput({name, ".mem_wdata"}, g.wdata, e.wdata);
      checkOutput({name, ".req_stable"}, 32'(g.unstable), 32'd0);
    end
    if (e.wb > 0 && g.wb > 0) begin
      checkOutput({name, ".wb_data"}, g.wbdata, e.wbdata);
      checkOutput({name, ".wb_latency"}, 32'(g.wb_cyc), 32'(e.req + 1));
    end
    exp_wb = (e.wb > 0) ? e.wbdata : last_wb;
    checkOutput({name, ".wb_hold"}, g.fin_wb, exp_wb);
    last_wb = exp_wb;
  endtask

  // Reset arrives in the second REQ cycle; an ack in the cycle right after
  // reset must be ignored and every output must read zero.
  task automatic run_reset_seq();
    op_valid    = 1'b1;
    op_load     = 1'b1;
    op_store    = 1'b0;
    op_size     = 2'b10;
    op_unsigned = 1'b0;
    addr        = 32'h0000_0300;
    store_data  = 32'h0;
    @(negedge clk);
    checkOutput("rst_seq.accept_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_seq.req2_mem_req", 32'(mem_req), 32'd1);
    rst      = 1'b1;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    checkOutput("rst_seq.ctrl_zero",
                32'({stall, wb_valid, misalign, timeout_err, mem_req, mem_we, mem_be}),
                32'd0);
    checkOutput("rst_seq.mem_addr_zero", mem_addr, 32'd0);
    checkOutput("rst_seq.mem_wdata_zero", mem_wdata, 32'd0);
    checkOutput("rst_seq.wb_data_zero", wb_data, 32'd0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_seq.late_ack_ignored",
                  32'({wb_valid, stall, mem_req, timeout_err}), 32'd0);
      checkOutput("rst_seq.wb_data_still_zero", wb_data, 32'd0);
      @(posedge clk);
      #1;
    end
    last_wb = 32'd0;
  endtask

  // Two word loads presented back to back; the memory acks every request
  // immediately with data derived from the address.
  task automatic run_back_to_back();
    int          idx;
    int          cyc;
    int          quiet;
    int          req_seg;
    int          stall_n;
    int          overlap;
    bit          prev_req;
    bit          s_stall;
    logic [31:0] seg_addr[$];
    logic [31:0] wb_q[$];
    logic [31:0] exp_addr[2];
    logic [31:0] exp_data[2];
    exp_addr[0] = 32'h0000_0000;
    exp_addr[1] = 32'h0000_0004;
    exp_data[0] = 32'hC0DE_0000;
    exp_data[1] = 32'hC0DE_0004;
    idx = 0; cyc = 0; quiet = 0; req_seg = 0; stall_n = 0; overlap = 0;
    prev_req = 1'b0;
    op_valid    = 1'b1;
    op_load     = 1'b1;
    op_store    = 1'b0;
    op_size     = 2'b10;
    op_unsigned = 1'b0;
    addr        = exp_addr[0];
    store_data  = 32'h0;
    while (quiet < 3 && cyc < 40) begin
      @(negedge clk);
      s_stall = stall;
      if (stall) stall_n++;
      if (mem_req) begin
        if (!prev_req) begin
          req_seg++;
          seg_addr.push_back(mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hC0DE_0000 + mem_addr;
      end
      prev_req = mem_req;
      if (wb_valid) begin
        wb_q.push_back(wb_data);
        if (mem_req) overlap++;
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (idx < 2) begin
        if (!s_stall) begin
          idx++;
          if (idx < 2) addr = exp_addr[idx];
          else         op_valid = 1'b0;
        end
      end else begin
        quiet++;
      end
      cyc++;
    end
    op_valid = 1'b0;
    checkOutput("b2b.ops_retired", 32'(idx), 32'd2);
    checkOutput("b2b.req_segments", 32'(req_seg), 32'd2);
    checkOutput("b2b.wb_pulses", 32'(wb_q.size()), 32'd2);
    checkOutput("b2b.stall_cycles", 32'(stall_n), 32'd4);
    checkOutput("b2b.overlap", 32'(overlap), 32'd0);
    for (int i = 0; i < 2 && i < seg_addr.size(); i++)
      checkOutput($sformatf("b2b.mem_addr%0d", i), seg_addr[i], exp_addr[i]);
    for (int i = 0; i < 2 && i < wb_q.size(); i++)
      checkOutput($sformatf("b2b.wb_data%0d", i), wb_q[i], exp_data[i]);
    last_wb = exp_data[1];
  endtask

  initial begin
    vec_t vecs[$];
    res_t got;
    res_t exp;
    op_t  op;
    int   sel;

    rst         = 1'b1;
    op_valid    = 1'b0;
    op_load     = 1'b0;
    op_store    = 1'b0;
    op_size     = 2'b00;
    op_unsigned = 1'b0;
    addr        = 32'h0;
    store_data  = 32'h0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    last_wb     = 32'h0;

    // Directed vectors: name, ld, st, size, uns, addr, sdata, ack, rdata |
    // mis, req, we, mem_addr, be, wdata, wb, wb_data, timeout
    vecs.push_back(make_vec("word_ld", 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF,
                            0, 1, 1'b0, 32'h100, 4'b1111, 32'h0, 1, 32'hDEADBEEF, 0));
    vecs.push_back(make_vec("byte_ld_s", 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1, 32'h80FF1234,
                            0, 1, 1'b0, 32'h100, 4'b1000, 32'h0, 1, 32'hFFFFFF80, 0));
    vecs.push_back(make_vec("byte_ld_u", 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1, 32'h80FF1234,
                            0, 1, 1'b0, 32'h100, 4'b1000, 32'h0, 1, 32'h00000080, 0));
    vecs.push_back(make_vec("half_st", 1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 3, 32'h0,
                            0, 3, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 0, 32'h0, 0));
    vecs.push_back(make_vec("mis_word", 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1, 32'h0,
                            1, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 0));
    vecs.push_back(make_vec("mis_half", 1'b1, 1'b0, 2'b01, 1'b0, 32'h005, 32'h0, 1, 32'h0,
                            1, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 0));
    vecs.push_back(make_vec("timeout", 1'b1, 1'b0, 2'b10, 1'b0, 32'h040, 32'h0, 0, 32'h0,
                            0, 15, 1'b0, 32'h040, 4'b1111, 32'h0, 0, 32'h0, 1));
    vecs.push_back(make_vec("after_to", 1'b1, 1'b0, 2'b10, 1'b0, 32'h044, 32'h0, 1, 32'h0BADF00D,
                            0, 1, 1'b0, 32'h044, 4'b1111, 32'h0, 1, 32'h0BADF00D, 0));
    vecs.push_back(make_vec("half_ld_s", 1'b1, 1'b0, 2'b01, 1'b0, 32'h006, 32'h0, 2, 32'h80011234,
                            0, 2, 1'b0, 32'h004, 4'b1100, 32'h0, 1, 32'hFFFF8001, 0));
    vecs.push_back(make_vec("byte_st", 1'b0, 1'b1, 2'b00, 1'b0, 32'h001, 32'h123456A5, 1, 32'h0,
                            0, 1, 1'b1, 32'h000, 4'b0010, 32'hA5A5A5A5, 0, 32'h0, 0));
    vecs.push_back(make_vec("ack_at_to", 1'b1, 1'b0, 2'b01, 1'b1, 32'h010, 32'h0, 15, 32'h1234FEDC,
                            0, 15, 1'b0, 32'h010, 4'b0011, 32'h0, 1, 32'h0000FEDC, 0));
    vecs.push_back(make_vec("size11", 1'b1, 1'b0, 2'b11, 1'b0, 32'h008, 32'h0, 1, 32'h55AA55AA,
                            0, 1, 1'b0, 32'h008, 4'b1111, 32'h0, 1, 32'h55AA55AA, 0));
    vecs.push_back(make_vec("ld_and_st", 1'b1, 1'b1, 2'b10, 1'b0, 32'h00C, 32'hFFFFFFFF, 2, 32'hCAFEF00D,
                            0, 2, 1'b0, 32'h00C, 4'b1111, 32'h0, 1, 32'hCAFEF00D, 0));
    vecs.push_back(make_vec("no_op", 1'b0, 1'b0, 2'b10, 1'b0, 32'h003, 32'h0, 1, 32'h0,
                            0, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 0));
    vecs.push_back(make_vec("word_st", 1'b0, 1'b1, 2'b10, 1'b0, 32'h1FC, 32'h87654321, 1, 32'h0,
                            0, 1, 1'b1, 32'h1FC, 4'b1111, 32'h87654321, 0, 32'h0, 0));
    vecs.push_back(make_vec("byte_ld_pos", 1'b1, 1'b0, 2'b00, 1'b0, 32'h021, 32'h0, 1, 32'h00007F00,
                            0, 1, 1'b0, 32'h020, 4'b0010, 32'h0, 1, 32'h0000007F, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.ctrl_zero",
                32'({stall, wb_valid, misalign, timeout_err, mem_req, mem_we, mem_be}), 32'd0);
    checkOutput("reset.mem_addr_zero", mem_addr, 32'd0);
    checkOutput("reset.wb_data_zero", wb_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed table: %0d vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, got);
      verify_op(vecs[i].name, vecs[i].exp, got);
    end

    $display("[TB] back-to-back loads");
    run_back_to_back();

    $display("[TB] reset during request");
    run_reset_seq();

    $display("[TB] randomized ops");
    for (int n = 0; n < 40; n++) begin
      op.ld    = 1'($urandom_range(0, 1));
      op.st    = 1'($urandom_range(0, 1));
      op.size  = 2'($urandom_range(0, 3));
      op.uns   = 1'($urandom_range(0, 1));
      op.addr  = 32'($urandom_range(0, 1023));
      op.sdata = $urandom();
      op.rdata = $urandom();
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      op.ack = 0;
      else if (sel == 1) op.ack = TIMEOUT;
      else if (sel == 2) op.ack = TIMEOUT + 1;
      else               op.ack = int'($urandom_range(1, 4));
      exp = model_op(op);
      applyStimulus(op, got);
      verify_op($sformatf("rand%0d", n), exp, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
